// File: rtl/inv_key_expand.sv
// inv_key_expand: AES-128 inverse key schedule. Emits round keys from round 10
// down to round 0, one per valid/ready handshake, then pulses done.
// Optional macro INV_KEY_EXPAND_FWD_DERIVE_EN: key_in is the cipher key, and
// the round-10 key is first derived in place by a 10-cycle forward pass
// that shares the same 4-byte S-box. Without the macro, key_in is the round-10 key.
module inv_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    // byte x sits (255 - x) bytes up from bit 0, and 255 - x == ~x
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, EMIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd2} state_t;
`endif

  state_t state;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w3;
  logic [31:0] sbox_in;
  logic [31:0] sbox_rot;
  logic [31:0] sbox_out;
  logic [31:0] temp;
  logic [3:0]  rcon_sel;
  logic [127:0] inv_next;

  assign {w0, w1, w2, w3} = round_key;

  // The inverse step needs the previous round's w3, which is w3 ^ w2.
  assign inv_w3 = w3 ^ w2;

`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
  logic [3:0]   fwd_cnt;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_next;

  // Share the S-box: forward pass uses the current w3, inverse pass the rebuilt w3.
  always_comb begin
    sbox_in  = inv_w3;
    rcon_sel = round_idx;
    if (state == FWD) begin
      sbox_in  = w3;
      rcon_sel = fwd_cnt;
    end
  end

  assign f0       = w0 ^ temp;
  assign f1       = w1 ^ f0;
  assign f2       = w2 ^ f1;
  assign f3       = w3 ^ f2;
  assign fwd_next = {f0, f1, f2, f3};
`else
  assign sbox_in  = inv_w3;
  assign rcon_sel = round_idx;
`endif

  // RotWord: top byte moves to the bottom.
  assign sbox_rot = {sbox_in[23:0], sbox_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sbox_out[gi*8 +: 8] = sbox(sbox_rot[gi*8 +: 8]);
    end
  endgenerate

  assign temp     = sbox_out ^ {rcon(rcon_sel), 24'h000000};
  assign inv_next = {w0 ^ temp, w1 ^ w0, w2 ^ w1, inv_w3};

  // Control FSM with registered handshake/status outputs and the key register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
      fwd_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            round_idx <= 4'd10;
            busy      <= 1'b1;
`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
            fwd_cnt   <= 4'd1;
            key_valid <= 1'b0;
            state     <= FWD;
`else
            key_valid <= 1'b1;
            state     <= EMIT;
`endif
          end
        end
`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
        FWD: begin
          round_key <= fwd_next;
          if (fwd_cnt == 4'd10) begin
            key_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            fwd_cnt <= fwd_cnt + 4'd1;
          end
        end
`endif
        EMIT: begin
          // key_valid is always high here, so key_ready alone marks a transfer
          if (key_ready) begin
            if (round_idx == 4'd0) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              round_key <= inv_next;
              round_idx <= round_idx - 4'd1;
            end
          end
        end
        default: begin
          key_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_expand.sv
// tb_inv_key_expand: self-checking bench for inv_key_expand. Works with or
// without INV_KEY_EXPAND_FWD_DERIVE_EN; the seed key and first-key latency
// follow the macro.
`timescale 1ns/1ps
module tb_inv_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  inv_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

`ifdef INV_KEY_EXPAND_FWD_DERIVE_EN
  localparam logic [127:0] SEED = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int LAT = 11;
`else
  localparam logic [127:0] SEED = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } key_vec_t;

  typedef struct {
    int stall_idx;
    int start_idx;
    int rst_idx;
    int exp_keys;
  } scen_t;

  key_vec_t key_tab[11];
  scen_t    scen_tab[5];
  key_vec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scenario(input int s);
    scen_t    sc;
    key_vec_t e;
    int       cyc;
    int       got;
    int       stall_cnt;
    int       emit_cycles;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    bit       mid_start_done;
    bit       last;
    bit       finished;
    bit       aborted;

    sc = scen_tab[s];
    held_key = '0;
    held_idx = '0;
    key_in    = SEED;
    start     = 1'b1;
    key_ready = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(key_tab[i]);
    step();
    start  = 1'b0;
    key_in = '0;
    check("busy_after_start", busy, 1);

    cyc = 1;
    while (!key_valid && cyc < 30) begin
      step();
      cyc++;
    end
    check("first_valid_latency", cyc, LAT);

    got = 0;
    stall_cnt = 0;
    emit_cycles = 0;
    mid_start_done = 0;
    last = 0;
    finished = 0;
    aborted = 0;
    for (int c = 0; c < 40 && !finished && !aborted; c++) begin
      key_ready = 1'b1;
      start = 1'b0;
      if (sc.stall_idx >= 0 && round_idx == sc.stall_idx && stall_cnt <= 2) begin
        if (stall_cnt == 0) begin
          held_key = round_key;
          held_idx = round_idx;
        end else begin
          check("stall_key_hold", round_key, held_key);
          check("stall_idx_hold", round_idx, held_idx);
        end
        if (stall_cnt < 2) key_ready = 1'b0;
        stall_cnt++;
      end
      if (sc.start_idx >= 0 && round_idx == sc.start_idx && !mid_start_done) begin
        start = 1'b1;
        key_in = ~SEED;
        mid_start_done = 1;
      end
      if (sc.start_idx >= 0 && round_idx == 0 && key_valid) begin
        start = 1'b1;
        key_in = ~SEED;
      end
      if (sc.rst_idx >= 0 && round_idx == sc.rst_idx && key_valid) begin
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_round_key", round_key, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_done", done, 0);
        check("keys_before_reset", got, sc.exp_keys);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
          step();
          check("post_rst_quiet", {done, key_valid, busy}, 0);
        end
        aborted = 1;
      end else begin
        emit_cycles++;
        if (key_valid && key_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_key", 0, 1);
          end else begin
            e = exp_q.pop_front();
            $display("xfer idx=%0d key=%h", round_idx, round_key);
            check("round_idx", round_idx, e.idx);
            check("round_key", round_key, e.key);
            got++;
            if (round_idx == 0) last = 1;
          end
        end
        step();
        start = 1'b0;
        if (last) begin
          check("done_pulse", done, 1);
          check("done_busy", busy, 0);
          check("done_key_valid", key_valid, 0);
          check("idle_round_idx", round_idx, 0);
          check("idle_round_key", round_key, key_tab[10].key);
          step();
          check("done_one_cycle", done, 0);
          check("start_on_final_ignored", busy, 0);
          check("key_count", got, sc.exp_keys);
          check("emit_cycles", emit_cycles, sc.exp_keys + ((sc.stall_idx >= 0) ? 2 : 0));
          check("queue_empty", exp_q.size(), 0);
          finished = 1;
        end
      end
    end
    if (!finished && !aborted) check("sequence_timeout", 0, 1);
    exp_q.delete();
    key_ready = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    key_tab[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    key_tab[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    key_tab[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    key_tab[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    key_tab[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    key_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    key_tab[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    key_tab[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    key_tab[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    key_tab[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    key_tab[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    // stall_idx, start_idx, rst_idx, keys transferred
    scen_tab[0] = '{-1, -1, -1, 11};
    scen_tab[1] = '{ 7, -1, -1, 11};
    scen_tab[2] = '{-1,  5, -1, 11};
    scen_tab[3] = '{-1, -1,  4,  6};
    scen_tab[4] = '{-1, -1, -1, 11};

    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    key_in = '0;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_key_valid", key_valid, 0);
    check("reset_done", done, 0);
    check("reset_round_key", round_key, 0);
    check("reset_round_idx", round_idx, 0);
    rst = 1'b0;
    step();

    for (int s = 0; s < 5; s++) begin
      $display("scenario %0d", s);
      run_scenario(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_expand.md
INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous active-high reset.
  start  input  1  request pulse; sampled only while busy=0.
  key_in  input  128  captured on accepted start; round-10 key (or cipher key, see REQ-019).
  busy  output  1  high from accepted start until the final key handshake completes.
  key_valid  output  1  round_key/round_idx hold a valid key.
  key_ready  input  1  consumer accepts the key when high together with key_valid.
  round_key  output  128  current round key; word0=[127:96] … word3=[31:0].
  round_idx  output  4  round number of round_key, 10 down to 0.
  done  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-003 Word and round-constant layout SHALL follow FIPS-197: RotWord moves the top byte of a word to the bottom, SubWord applies the AES S-box per byte, and Rcon[r] = {rc_r,24'h0} with rc_1..rc_10 = 01,02,04,08,10,20,40,80,1b,36.
REQ-004 The state machine SHALL have states IDLE, FWD (only with REQ-019) and EMIT.
REQ-005 In IDLE with start=1, the block SHALL capture key_in, set round_idx=10, and go to EMIT (or FWD per REQ-019); busy SHALL rise the next cycle.
REQ-006 In EMIT, key_valid SHALL be 1 and round_key SHALL hold the key for round_idx.
REQ-007 A transfer SHALL occur on any cycle with key_valid=1 and key_ready=1.
REQ-008 While key_ready=0, round_key and round_idx SHALL remain stable.
REQ-009 On a transfer with round_idx=r>0, the register SHALL update on the same edge to the round r-1 key, and round_idx SHALL become r-1:
  w3'=w3^w2
  w2'=w2^w1
  w1'=w1^w0
  w0'=w0^SubWord(RotWord(w3'))^Rcon[r]
REQ-010 Throughput SHALL be one key per cycle when key_ready is held high, giving 11 keys in 11 consecutive cycles.
REQ-011 The inverse step SHALL be single-cycle combinational from the key register, using one 4-byte S-box instance.
REQ-012 On the transfer with round_idx=0, the block SHALL return to IDLE, and on the next cycle key_valid=0, busy=0 and done=1 for exactly one cycle.
REQ-013 start SHALL be ignored while busy=1, including the cycle of the final transfer.
REQ-014 After return to IDLE, round_key SHALL retain the round-0 key and round_idx SHALL read 0, with key_valid=0.
REQ-015 round_idx SHALL never wrap below 0 or exceed 10.

Reset
REQ-016 When rst=1 at a rising edge, the block SHALL enter IDLE with busy=0, key_valid=0, done=0, round_key=0 and round_idx=0.
REQ-017 rst SHALL take priority over start and over any transfer in the same cycle.
REQ-018 A reset mid-operation SHALL abort the sequence with no done pulse and no further key_valid until a new start.

Configuration
REQ-019 With macro INV_KEY_EXPAND_FWD_DERIVE_EN defined:
  key_in SHALL be the cipher key.
  After start the block SHALL spend exactly 10 cycles in FWD computing the forward schedule in-place (Rcon 1..10) with busy=1 and key_valid=0, sharing the same S-box instance.
  It SHALL then enter EMIT with round 10, so the first key_valid occurs 11 cycles after the start edge.
REQ-020 Without INV_KEY_EXPAND_FWD_DERIVE_EN:
  key_in SHALL be the round-10 key.
  FWD SHALL not exist.
  key_valid SHALL assert the cycle after the start edge.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  (a) Macro off, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> idx10 d014f9a8…, idx9 ac7766f319fadc2128d12941575c006e, idx1 a0fafe1788542cb123a339392a6c7605, idx0 2b7e151628aed2a6abf7158809cf4f3c on 11 consecutive cycles, then done=1 for one cycle.
  (b) Macro on, key_in=2b7e151628aed2a6abf7158809cf4f3c -> first key_valid 11 cycles after start with round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, then the same sequence as (a).
  (c) key_ready toggled 1,0,0,1 during idx 7 -> round_key and round_idx held through the stall, and no key skipped or repeated.
  (d) start pulsed at idx 5 and on the final transfer cycle -> ignored, sequence unchanged, single done pulse.
  (e) rst asserted at idx 4 -> next cycle busy=0, key_valid=0, round_key=0, no done; a new start then produces the full correct sequence.
